function_g_sweeper: RTL
=======================

Name: function_g_sweeper

Overview:
- Sequential test-driver stage wrapped around the switch-level 2-bit function block (function_g). It sits directly upstream and drives the A/B operand pair, and directly downstream and samples the g response.
- On start it steps through all 16 {A,B} combinations. For each one it waits a programmable settle window so the transistor-level propagation delays resolve, then captures g.
- It builds a 16-entry truth table, counts the ones, and reports pass/fail against a golden table.

Parameters:
- SETTLE_CYCLES, 4, clock cycles operands are held before g is sampled; legal range 1..15.
- EXPECTED, 16'h0000, golden truth table; bit i = expected g for index i = {A,B}.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  sweep request; sampled only in IDLE.
- g_in  input  1  g output of the function block under test.
- A  output  2  operand A to the function block; equals idx[3:2].
- B  output  2  operand B to the function block; equals idx[1:0].
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- truth_table  output  16  captured g values; bit i = g for idx i.
- ones_count  output  5  number of 1s captured (0..16).
- pass  output  1  (truth_table == EXPECTED); valid from done onward.

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous and active-low (one clock; reset is asynchronous and active-low). All state resets immediately when rst_n goes low.
- Internal registers: state, idx[3:0], settle counter cnt[3:0].
- Reset values: state=IDLE, idx=0 (so A=0, B=0), cnt=0, busy=0, done=0, truth_table=0, ones_count=0, pass=0.
- Operand outputs: A and B come directly from idx, with no extra register stage.
- IDLE:
  - start=1 at an edge → idx<=0, cnt<=0, truth_table<=0, ones_count<=0, pass<=0, busy<=1, go to SETTLE.
  - start=0 → hold all outputs. After a sweep this leaves A=3, B=3 and the previous results visible.
- SETTLE:
  - If cnt==SETTLE_CYCLES-1, go to CAPTURE; otherwise cnt<=cnt+1.
  - Occupies exactly SETTLE_CYCLES cycles per vector.
  - g_in is ignored during SETTLE; glitches here must not affect results.
- CAPTURE (one cycle):
  - truth_table[idx]<=g_in and ones_count<=ones_count+g_in.
  - If idx==15, go to DONE.
  - Otherwise idx<=idx+1, cnt<=0, go back to SETTLE.
- DONE (one cycle):
  - done=1, busy=0.
  - pass<=(truth_table==EXPECTED). Use the final value, including the bit captured on the previous edge.
  - Next state is IDLE.
- Timing: call the start-accepting edge edge 0.
  - Vector i is captured at edge (i+1)*(SETTLE_CYCLES+1).
  - The last capture is at edge 16*(SETTLE_CYCLES+1). done is high during the following cycle.
  - busy rises after edge 0 and falls when DONE is entered, i.e. high for 16*(SETTLE_CYCLES+1) cycles.
- start handling:
  - Ignored in SETTLE, CAPTURE and DONE; no queuing.
  - start held high continuously → the next sweep begins at the first IDLE edge after DONE, i.e. one idle cycle between sweeps.
- Reset mid-sweep: immediate return to reset values. No done pulse is emitted and partial results are discarded.
- Width rules:
  - ones_count is 5 bits and saturation is impossible (maximum 16).
  - idx does not wrap within a sweep; it stops at 15.
- SETTLE_CYCLES=1 must work: 2 cycles per vector, 32 cycles per sweep.

Test Plan:
1. Reset: assert rst_n=0 mid-clock → A=0, B=0, busy=0, done=0, truth_table=0, ones_count=0, pass=0 without waiting for a clock edge.
2. g_in tied to 1, SETTLE_CYCLES=4, single-cycle start → A/B step 0..15 every 5 cycles; done pulses in the cycle after edge 80; truth_table=16'hFFFF, ones_count=16; busy high for exactly 80 cycles.
3. Bench drives g_in = A[1] & ~B[0], EXPECTED=16'h5500 → truth_table=16'h5500, ones_count=4, pass=1 with done. Repeat with EXPECTED=16'h5501 → pass=0.
4. Bench forces g_in=1 during the SETTLE cycles of every vector and drives 0 at the CAPTURE edge → truth_table=0, ones_count=0.
5. Start pulses during busy are ignored (exactly one done per 80 cycles). With start held high, the second sweep begins one cycle after done, and truth_table clears to 0 at the start of the second sweep.
6. Reset asserted while idx=5, then released, then start → no done for the aborted sweep; a full fresh sweep completes with correct results. Repeat with SETTLE_CYCLES=1 → done in the cycle after edge 32.

Source files
------------

// File: rtl/function_g_sweeper.sv
// Test driver for the 2-bit function block: sweeps all 16 {A,B} operand pairs,
// waits a settle window per vector, captures g and checks it against a golden table.
module function_g_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [15:0] EXPECTED      = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        g_in,
  output logic [1:0]  A,
  output logic [1:0]  B,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  ones_count,
  output logic        pass
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TT_W   = 16;
  localparam int unsigned ONES_W = 5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              busy_nxt, done_nxt, pass_nxt;
  logic [TT_W-1:0]   tt_nxt;
  logic [ONES_W-1:0] ones_nxt;

  // Operands are the vector index itself, no extra pipeline stage.
  assign A = idx[3:2];
  assign B = idx[1:0];

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= '0;
      ones_count  <= '0;
      pass        <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      truth_table <= tt_nxt;
      ones_count  <= ones_nxt;
      pass        <= pass_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    tt_nxt    = truth_table;
    ones_nxt  = ones_count;
    pass_nxt  = pass;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          idx_nxt   = '0;
          cnt_nxt   = '0;
          tt_nxt    = '0;
          ones_nxt  = '0;
          pass_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end

      // g_in is deliberately not looked at while operands settle.
      ST_SETTLE: begin
        if (cnt == CNT_LAST) begin
          state_nxt = ST_CAPTURE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_CAPTURE: begin
        tt_nxt[idx] = g_in;
        ones_nxt    = ones_count + ONES_W'(g_in);
        if (idx == IDX_LAST) begin
          // Verdict includes the bit captured on this edge, so pass is valid with done.
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (tt_nxt == EXPECTED);
          state_nxt = ST_DONE;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          cnt_nxt   = '0;
          state_nxt = ST_SETTLE;
        end
      end

      ST_DONE: begin
        pass_nxt  = (truth_table == EXPECTED);
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
